// File: rtl/dcache_pkg.sv
// ============================================================================
// dcache_pkg : shared types, default widths and helpers for assoc_dcache_wb
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dcache_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_OFFSET_W = 3;
    localparam int DEF_LINES    = 16;

    localparam int TAG_W = DEF_ADDR_W - DEF_OFFSET_W;
    localparam int IDX_W = $clog2(DEF_LINES);

    // Wide enough for any practical address width; callers cast to their own width.
    localparam int LINE_ADDR_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2,
        DONE      = 2'd3
    } dc_state_e;

    function automatic logic [LINE_ADDR_MAX_W-1:0] line_addr(
        input logic [LINE_ADDR_MAX_W-1:0] tag,
        input int                         offset_w
    );
        return tag << offset_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/assoc_dcache_wb_tag_match.sv
// ============================================================================
// assoc_tag_match : parallel tag comparison and lowest-invalid-line search
// Revision        : 1.0
// ============================================================================
`default_nettype none

module assoc_tag_match #(
    parameter int LINES  = 16,
    parameter int TAG_W  = 29,
    parameter int IDX_W  = 4
) (
    input  logic [TAG_W-1:0]            i_tag,
    input  logic [LINES-1:0][TAG_W-1:0] i_tags,
    input  logic [LINES-1:0]            i_valid,
    output logic                        o_hit,
    output logic [IDX_W-1:0]            o_hit_idx,
    output logic                        o_multi_hit,
    output logic [IDX_W-1:0]            o_first_invalid,
    output logic                        o_any_invalid
);

    always_comb begin
        o_hit       = 1'b0;
        o_hit_idx   = '0;
        o_multi_hit = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if (i_valid[i] && (i_tags[i] == i_tag)) begin
                if (o_hit) begin
                    o_multi_hit = 1'b1;
                end
                o_hit     = 1'b1;
                o_hit_idx = IDX_W'(i);
            end
        end
    end

    // Scanning downward leaves the lowest invalid index as the final value.
    always_comb begin
        o_any_invalid   = 1'b0;
        o_first_invalid = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (!i_valid[i]) begin
                o_any_invalid   = 1'b1;
                o_first_invalid = IDX_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/assoc_dcache_wb.sv
// ============================================================================
// assoc_dcache_wb : fully-associative write-back/write-allocate data cache,
//                   one word per line, round-robin replacement, req/ack buses
// Revision        : 1.0
// ============================================================================
`default_nettype none

module assoc_dcache_wb
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int LINES    = DEF_LINES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_done,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int LTAG_W = ADDR_W - OFFSET_W;
    localparam int LIDX_W = $clog2(LINES);

    dc_state_e                   r_state;
    logic [LINES-1:0]            r_valid;
    logic [LINES-1:0]            r_dirty;
    logic [LINES-1:0][LTAG_W-1:0] r_tags;
    logic [DATA_W-1:0]           r_data [LINES];
    logic [LIDX_W-1:0]           r_vptr;
    logic [LIDX_W-1:0]           r_victim;

    logic [LTAG_W-1:0]           w_req_tag;
    logic                        w_hit;
    logic                        w_multi_hit;
    logic                        w_any_invalid;
    logic [LIDX_W-1:0]           w_hit_idx;
    logic [LIDX_W-1:0]           w_first_invalid;
    logic [LIDX_W-1:0]           w_victim;
    logic [ADDR_W-1:0]           w_req_laddr;
    logic [ADDR_W-1:0]           w_victim_laddr;

    assign w_req_tag      = LTAG_W'(i_cpu_addr >> OFFSET_W);
    assign w_victim       = w_any_invalid ? w_first_invalid : r_vptr;
    assign w_req_laddr    = ADDR_W'(line_addr(LINE_ADDR_MAX_W'(w_req_tag), OFFSET_W));
    assign w_victim_laddr = ADDR_W'(line_addr(LINE_ADDR_MAX_W'(r_tags[w_victim]), OFFSET_W));

    assoc_tag_match #(
        .LINES (LINES),
        .TAG_W (LTAG_W),
        .IDX_W (LIDX_W)
    ) u_tag_match (
        .i_tag           (w_req_tag),
        .i_tags          (r_tags),
        .i_valid         (r_valid),
        .o_hit           (w_hit),
        .o_hit_idx       (w_hit_idx),
        .o_multi_hit     (w_multi_hit),
        .o_first_invalid (w_first_invalid),
        .o_any_invalid   (w_any_invalid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_tags      <= '0;
            for (int i = 0; i < LINES; i++) begin
                r_data[i] <= '0;
            end
            r_vptr      <= '0;
            r_victim    <= '0;
            o_cpu_done  <= 1'b0;
            o_cpu_rdata <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_cpu_done <= 1'b0;
                    if (i_cpu_req) begin
                        if (w_hit) begin
                            if (i_cpu_we) begin
                                r_data[w_hit_idx]  <= i_cpu_wdata;
                                r_dirty[w_hit_idx] <= 1'b1;
                                o_cpu_rdata        <= i_cpu_wdata;
                            end else begin
                                o_cpu_rdata <= r_data[w_hit_idx];
                            end
                            o_cpu_done <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_victim <= w_victim;
                            // Only evicting a valid line consumes a round-robin slot.
                            if (!w_any_invalid) begin
                                r_vptr <= r_vptr + LIDX_W'(1);
                            end
                            if (r_valid[w_victim] && r_dirty[w_victim]) begin
                                o_mem_req   <= 1'b1;
                                o_mem_we    <= 1'b1;
                                o_mem_addr  <= w_victim_laddr;
                                o_mem_wdata <= r_data[w_victim];
                                r_state     <= WRITEBACK;
                            end else if (i_cpu_we) begin
                                r_tags[w_victim]  <= w_req_tag;
                                r_data[w_victim]  <= i_cpu_wdata;
                                r_valid[w_victim] <= 1'b1;
                                r_dirty[w_victim] <= 1'b1;
                                o_cpu_rdata       <= i_cpu_wdata;
                                o_cpu_done        <= 1'b1;
                                r_state           <= DONE;
                            end else begin
                                o_mem_req  <= 1'b1;
                                o_mem_we   <= 1'b0;
                                o_mem_addr <= w_req_laddr;
                                r_state    <= FILL;
                            end
                        end
                    end
                end

                WRITEBACK: begin
                    if (i_mem_ack) begin
                        r_dirty[r_victim] <= 1'b0;
                        if (i_cpu_we) begin
                            r_tags[r_victim]  <= w_req_tag;
                            r_data[r_victim]  <= i_cpu_wdata;
                            r_valid[r_victim] <= 1'b1;
                            r_dirty[r_victim] <= 1'b1;
                            o_cpu_rdata       <= i_cpu_wdata;
                            o_mem_req         <= 1'b0;
                            o_cpu_done        <= 1'b1;
                            r_state           <= DONE;
                        end else begin
                            // Request stays asserted: the fill follows back-to-back.
                            o_mem_we   <= 1'b0;
                            o_mem_addr <= w_req_laddr;
                            r_state    <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (i_mem_ack) begin
                        r_tags[r_victim]  <= w_req_tag;
                        r_data[r_victim]  <= i_mem_rdata;
                        r_valid[r_victim] <= 1'b1;
                        r_dirty[r_victim] <= 1'b0;
                        o_cpu_rdata       <= i_mem_rdata;
                        o_mem_req         <= 1'b0;
                        o_cpu_done        <= 1'b1;
                        r_state           <= DONE;
                    end
                end

                DONE: begin
                    o_cpu_done <= 1'b0;
                    r_state    <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    a_unique_tag : assert property (@(posedge clk) disable iff (!rst_n) !w_multi_hit);

endmodule

`default_nettype wire
